// File: rtl/l15_fwd_responder.sv
// rtl/l15_fwd_responder.sv - L1.5 responder for L2 LOAD/STORE/INV forward requests
// Optional counters: define L15_FWD_RESPONDER_STATS_EN
module l15_fwd_responder #(
    parameter logic [7:0] LOAD_FWD_TYPE     = 8'd16,
    parameter logic [7:0] STORE_FWD_TYPE    = 8'd17,
    parameter logic [7:0] INV_FWD_TYPE      = 8'd18,
    parameter logic [7:0] LOAD_FWDACK_TYPE  = 8'd19,
    parameter logic [7:0] STORE_FWDACK_TYPE = 8'd20,
    parameter logic [7:0] INV_FWDACK_TYPE   = 8'd21
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [13:0]  chipid,
    input  logic [7:0]   coreid_x,
    input  logic [7:0]   coreid_y,
    input  logic         noc2_valid_in,
    input  logic [63:0]  noc2_data_in,
    output logic         noc2_ready_in,
    output logic         noc3_valid_out,
    output logic [63:0]  noc3_data_out,
    input  logic         noc3_ready_out,
    output logic         lookup_valid,
    output logic [39:0]  lookup_addr,
    output logic [1:0]   lookup_op,
    input  logic         lookup_hit,
    input  logic         lookup_dirty,
    input  logic [127:0] lookup_data,
    output logic         err_drop
`ifdef L15_FWD_RESPONDER_STATS_EN
    ,
    output logic [15:0]  cnt_fwd_rx,
    output logic [15:0]  cnt_dirty_tx,
    output logic [15:0]  cnt_drop
`endif
);

    typedef enum logic [3:0] {
        IDLE, RX_ADDR, RX_SRC, DRAIN, LOOKUP, WAIT, TX_HDR, TX_ADDR, TX_D0, TX_D1
    } state_t;

    state_t         state;
    logic [7:0]     req_type;
    logic [7:0]     req_mshrid;
    logic [7:0]     req_len;
    logic [7:0]     drain_cnt;
    logic           hdr_ok;
    logic [29:0]    req_src;
    logic           rsp_dirty;
    logic [127:0]   rsp_data;
    logic [7:0]     ack_type;
    logic           noc2_fire;
    logic           type_legal;
    logic           dst_match;
    logic           fwd_ok;
    logic           dirty_rsp;

    assign noc2_fire  = noc2_valid_in && noc2_ready_in;
    assign type_legal = (noc2_data_in[21:14] == LOAD_FWD_TYPE)  ||
                        (noc2_data_in[21:14] == STORE_FWD_TYPE) ||
                        (noc2_data_in[21:14] == INV_FWD_TYPE);
    assign dst_match  = (noc2_data_in[63:34] == {chipid, coreid_x, coreid_y});
    assign fwd_ok     = (state == RX_SRC) && noc2_fire && hdr_ok && (req_len == 8'd2);
    assign dirty_rsp  = lookup_hit && lookup_dirty;

    always_comb begin
        ack_type = INV_FWDACK_TYPE;
        if (req_type == LOAD_FWD_TYPE)
            ack_type = LOAD_FWDACK_TYPE;
        else if (req_type == STORE_FWD_TYPE)
            ack_type = STORE_FWDACK_TYPE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            noc2_ready_in  <= 1'b1;
            noc3_valid_out <= 1'b0;
            noc3_data_out  <= '0;
            lookup_valid   <= 1'b0;
            lookup_addr    <= '0;
            lookup_op      <= 2'd0;
            err_drop       <= 1'b0;
            req_type       <= '0;
            req_mshrid     <= '0;
            req_len        <= '0;
            drain_cnt      <= '0;
            hdr_ok         <= 1'b0;
            req_src        <= '0;
            rsp_dirty      <= 1'b0;
            rsp_data       <= '0;
        end else begin
            err_drop     <= 1'b0;
            lookup_valid <= 1'b0;
            case (state)
                IDLE: if (noc2_fire) begin
                    req_type   <= noc2_data_in[21:14];
                    req_mshrid <= noc2_data_in[13:6];
                    req_len    <= noc2_data_in[29:22];
                    hdr_ok     <= dst_match && type_legal;
                    // A zero-length message is complete at its header
                    if (noc2_data_in[29:22] == 8'd0)
                        err_drop <= 1'b1;
                    else
                        state <= RX_ADDR;
                end
                RX_ADDR: if (noc2_fire) begin
                    lookup_addr <= noc2_data_in[39:0];
                    if (req_len == 8'd1) begin
                        err_drop <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        state <= RX_SRC;
                    end
                end
                RX_SRC: if (noc2_fire) begin
                    req_src <= noc2_data_in[63:34];
                    if (fwd_ok) begin
                        state         <= LOOKUP;
                        noc2_ready_in <= 1'b0;
                        lookup_valid  <= 1'b1;
                        lookup_op     <= (req_type == LOAD_FWD_TYPE) ? 2'd0 : 2'd1;
                    end else begin
                        err_drop  <= 1'b1;
                        drain_cnt <= req_len - 8'd2;
                        state     <= (req_len == 8'd2) ? IDLE : DRAIN;
                    end
                end
                DRAIN: if (noc2_fire) begin
                    drain_cnt <= drain_cnt - 8'd1;
                    if (drain_cnt == 8'd1)
                        state <= IDLE;
                end
                LOOKUP: state <= WAIT;
                WAIT: begin
                    rsp_dirty      <= dirty_rsp;
                    rsp_data       <= lookup_data;
                    noc3_valid_out <= 1'b1;
                    noc3_data_out  <= {req_src, 4'h0, (dirty_rsp ? 8'd3 : 8'd1),
                                       ack_type, req_mshrid, 6'h0};
                    state          <= TX_HDR;
                end
                TX_HDR: if (noc3_ready_out) begin
                    noc3_data_out <= {24'h0, lookup_addr};
                    state         <= TX_ADDR;
                end
                TX_ADDR: if (noc3_ready_out) begin
                    if (rsp_dirty) begin
                        noc3_data_out <= rsp_data[63:0];
                        state         <= TX_D0;
                    end else begin
                        noc3_valid_out <= 1'b0;
                        noc3_data_out  <= '0;
                        noc2_ready_in  <= 1'b1;
                        state          <= IDLE;
                    end
                end
                TX_D0: if (noc3_ready_out) begin
                    noc3_data_out <= rsp_data[127:64];
                    state         <= TX_D1;
                end
                TX_D1: if (noc3_ready_out) begin
                    noc3_valid_out <= 1'b0;
                    noc3_data_out  <= '0;
                    noc2_ready_in  <= 1'b1;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef L15_FWD_RESPONDER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_fwd_rx   <= '0;
            cnt_dirty_tx <= '0;
            cnt_drop     <= '0;
        end else begin
            if (fwd_ok && cnt_fwd_rx != 16'hFFFF)
                cnt_fwd_rx <= cnt_fwd_rx + 16'd1;
            if (state == WAIT && dirty_rsp && cnt_dirty_tx != 16'hFFFF)
                cnt_dirty_tx <= cnt_dirty_tx + 16'd1;
            if (err_drop && cnt_drop != 16'hFFFF)
                cnt_drop <= cnt_drop + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_l15_fwd_responder.sv
// tb/tb_l15_fwd_responder.sv - directed self-checking bench for l15_fwd_responder
module tb_l15_fwd_responder;

    localparam logic [13:0] OWN_C = 14'h0123;
    localparam logic [7:0]  OWN_X = 8'h04;
    localparam logic [7:0]  OWN_Y = 8'h05;
    localparam logic [13:0] REQ_C = 14'h0ABC;
    localparam logic [7:0]  REQ_X = 8'h11;
    localparam logic [7:0]  REQ_Y = 8'h22;

    logic         clk;
    logic         rst_n;
    logic         noc2_valid_in;
    logic [63:0]  noc2_data_in;
    logic         noc2_ready_in;
    logic         noc3_valid_out;
    logic [63:0]  noc3_data_out;
    logic         noc3_ready_out;
    logic         lookup_valid;
    logic [39:0]  lookup_addr;
    logic [1:0]   lookup_op;
    logic         lookup_hit;
    logic         lookup_dirty;
    logic [127:0] lookup_data;
    logic         err_drop;
`ifdef L15_FWD_RESPONDER_STATS_EN
    logic [15:0]  cnt_fwd_rx;
    logic [15:0]  cnt_dirty_tx;
    logic [15:0]  cnt_drop;
`endif

    int checks;
    int errors;
    int lk_cnt;
    int drop_cnt;
    int n3_cnt;
    logic [1:0]  lk_op;
    logic [39:0] lk_addr;
    logic [63:0] rx [0:7];
    int          rx_n;
    logic        rdy_seen;
    logic        stable;

    l15_fwd_responder dut (
        .clk(clk), .rst_n(rst_n), .chipid(OWN_C), .coreid_x(OWN_X), .coreid_y(OWN_Y),
        .noc2_valid_in(noc2_valid_in), .noc2_data_in(noc2_data_in), .noc2_ready_in(noc2_ready_in),
        .noc3_valid_out(noc3_valid_out), .noc3_data_out(noc3_data_out), .noc3_ready_out(noc3_ready_out),
        .lookup_valid(lookup_valid), .lookup_addr(lookup_addr), .lookup_op(lookup_op),
        .lookup_hit(lookup_hit), .lookup_dirty(lookup_dirty), .lookup_data(lookup_data),
        .err_drop(err_drop)
`ifdef L15_FWD_RESPONDER_STATS_EN
        , .cnt_fwd_rx(cnt_fwd_rx), .cnt_dirty_tx(cnt_dirty_tx), .cnt_drop(cnt_drop)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        lk_cnt = 0; drop_cnt = 0; n3_cnt = 0; lk_op = '0; lk_addr = '0;
        forever begin
            @(negedge clk);
            if (lookup_valid) begin lk_cnt++; lk_op = lookup_op; lk_addr = lookup_addr; end
            if (err_drop) drop_cnt++;
            if (noc3_valid_out) n3_cnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    function automatic logic [63:0] mk_hdr(input logic [13:0] c, input logic [7:0] x, input logic [7:0] y,
                                           input logic [7:0] len, input logic [7:0] typ, input logic [7:0] msh);
        return {c, x, y, 4'h0, len, typ, msh, 6'h0};
    endfunction

    task automatic send_flit(input logic [63:0] d);
        int t = 0;
        noc2_valid_in = 1'b1;
        noc2_data_in  = d;
        while (!noc2_ready_in && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) begin checks++; errors++; $display("FAIL send_flit_timeout got ready 0 exp 1"); end
        @(posedge clk); #1;
    endtask

    task automatic send_msg(input logic [63:0] h, input logic [63:0] a, input logic [63:0] s);
        send_flit(h); send_flit(a); send_flit(s);
        noc2_valid_in = 1'b0;
    endtask

    task automatic wait_reply(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!noc3_valid_out && n < 30);
    endtask

    task automatic recv_reply(input int stall_idx, input int stall_cyc);
        int t = 0;
        int total = 64;
        logic [63:0] held;
        rx_n = 0; rdy_seen = 1'b0; stable = 1'b1;
        while (rx_n < total && t < 200) begin
            if (noc3_valid_out) begin
                if (noc2_ready_in) rdy_seen = 1'b1;
                if (rx_n == stall_idx) begin
                    noc3_ready_out = 1'b0;
                    held = noc3_data_out;
                    repeat (stall_cyc) begin
                        @(negedge clk);
                        if (noc3_data_out !== held || noc3_valid_out !== 1'b1) stable = 1'b0;
                        if (noc2_ready_in) rdy_seen = 1'b1;
                    end
                    noc3_ready_out = 1'b1;
                end
                rx[rx_n] = noc3_data_out;
                if (rx_n == 0) total = int'(noc3_data_out[29:22]) + 1;
                if (total > 8) total = 8;
                rx_n++;
            end
            @(negedge clk); t++;
        end
        if (t >= 200) begin checks++; errors++; $display("FAIL recv_reply_timeout got %0d flits", rx_n); end
    endtask

    task automatic do_load(input logic [7:0] msh, input logic [39:0] addr, input logic [127:0] d, output int n);
        lookup_hit = 1'b1; lookup_dirty = 1'b1; lookup_data = d;
        send_msg(mk_hdr(OWN_C, OWN_X, OWN_Y, 8'd2, 8'd16, msh), {24'h0, addr}, mk_hdr(REQ_C, REQ_X, REQ_Y, 8'd0, 8'd0, 8'd0));
        wait_reply(n);
        recv_reply(-1, 0);
    endtask

    task automatic test_reset();
        checks++; if (noc2_ready_in !== 1'b1) begin errors++; $display("FAIL reset_noc2_ready got %0h exp 1", noc2_ready_in); end
        checks++; if (noc3_valid_out !== 1'b0) begin errors++; $display("FAIL reset_noc3_valid got %0h exp 0", noc3_valid_out); end
        checks++; if (noc3_data_out !== 64'h0) begin errors++; $display("FAIL reset_noc3_data got %0h exp 0", noc3_data_out); end
        checks++; if (lookup_valid !== 1'b0) begin errors++; $display("FAIL reset_lookup_valid got %0h exp 0", lookup_valid); end
        checks++; if (lookup_addr !== 40'h0) begin errors++; $display("FAIL reset_lookup_addr got %0h exp 0", lookup_addr); end
        checks++; if (lookup_op !== 2'd0) begin errors++; $display("FAIL reset_lookup_op got %0h exp 0", lookup_op); end
        checks++; if (err_drop !== 1'b0) begin errors++; $display("FAIL reset_err_drop got %0h exp 0", err_drop); end
    endtask

    task automatic test_load_dirty();
        int n;
        int l0 = lk_cnt;
        do_load(8'h2A, 40'h12_3456_7880, {64'hB, 64'hA}, n);
        checks++; if (n + 2 != 5) begin errors++; $display("FAIL load_latency got %0d exp 5", n + 2); end
        checks++; if (rx_n != 4) begin errors++; $display("FAIL load_flits got %0d exp 4", rx_n); end
        checks++; if (rx[0] !== mk_hdr(REQ_C, REQ_X, REQ_Y, 8'd3, 8'd19, 8'h2A)) begin errors++; $display("FAIL load_hdr got %0h exp %0h", rx[0], mk_hdr(REQ_C, REQ_X, REQ_Y, 8'd3, 8'd19, 8'h2A)); end
        checks++; if (rx[1] !== 64'h0000_0012_3456_7880) begin errors++; $display("FAIL load_addr got %0h exp 1234567880", rx[1]); end
        checks++; if (rx[2] !== 64'hA) begin errors++; $display("FAIL load_d0 got %0h exp a", rx[2]); end
        checks++; if (rx[3] !== 64'hB) begin errors++; $display("FAIL load_d1 got %0h exp b", rx[3]); end
        checks++; if (lk_cnt - l0 != 1) begin errors++; $display("FAIL load_lookup_pulses got %0d exp 1", lk_cnt - l0); end
        checks++; if (lk_op !== 2'd0) begin errors++; $display("FAIL load_lookup_op got %0d exp 0", lk_op); end
        checks++; if (lk_addr !== 40'h12_3456_7880) begin errors++; $display("FAIL load_lookup_addr got %0h exp 1234567880", lk_addr); end
        checks++; if (noc2_ready_in !== 1'b1) begin errors++; $display("FAIL load_idle_ready got %0h exp 1", noc2_ready_in); end
    endtask

    task automatic test_inv_miss();
        int n;
        lookup_hit = 1'b0; lookup_dirty = 1'b1; lookup_data = {64'h5, 64'h6};
        send_msg(mk_hdr(OWN_C, OWN_X, OWN_Y, 8'd2, 8'd18, 8'h11), {24'h0, 40'h00_0000_0040}, mk_hdr(REQ_C, REQ_X, REQ_Y, 8'd0, 8'd0, 8'd0));
        wait_reply(n);
        recv_reply(-1, 0);
        checks++; if (lk_op !== 2'd1) begin errors++; $display("FAIL inv_lookup_op got %0d exp 1", lk_op); end
        checks++; if (rx_n != 2) begin errors++; $display("FAIL inv_flits got %0d exp 2", rx_n); end
        checks++; if (rx[0] !== mk_hdr(REQ_C, REQ_X, REQ_Y, 8'd1, 8'd21, 8'h11)) begin errors++; $display("FAIL inv_hdr got %0h exp %0h", rx[0], mk_hdr(REQ_C, REQ_X, REQ_Y, 8'd1, 8'd21, 8'h11)); end
        checks++; if (noc3_valid_out !== 1'b0 || noc2_ready_in !== 1'b1) begin errors++; $display("FAIL inv_idle got valid %0h ready %0h exp 0 1", noc3_valid_out, noc2_ready_in); end
    endtask

    task automatic test_store_stall();
        int n;
        lookup_hit = 1'b1; lookup_dirty = 1'b0; lookup_data = {64'h7, 64'h8};
        send_msg(mk_hdr(OWN_C, OWN_X, OWN_Y, 8'd2, 8'd17, 8'h33), {24'h0, 40'hAB_CDEF_0100}, mk_hdr(REQ_C, REQ_X, REQ_Y, 8'd0, 8'd0, 8'd0));
        wait_reply(n);
        recv_reply(1, 4);
        checks++; if (lk_op !== 2'd1) begin errors++; $display("FAIL store_lookup_op got %0d exp 1", lk_op); end
        checks++; if (rx_n != 2) begin errors++; $display("FAIL store_flits got %0d exp 2", rx_n); end
        checks++; if (rx[0] !== mk_hdr(REQ_C, REQ_X, REQ_Y, 8'd1, 8'd20, 8'h33)) begin errors++; $display("FAIL store_hdr got %0h exp %0h", rx[0], mk_hdr(REQ_C, REQ_X, REQ_Y, 8'd1, 8'd20, 8'h33)); end
        checks++; if (rx[1] !== 64'h0000_00AB_CDEF_0100) begin errors++; $display("FAIL store_addr got %0h exp abcdef0100", rx[1]); end
        checks++; if (stable !== 1'b1) begin errors++; $display("FAIL store_stall_stable got %0h exp 1", stable); end
        checks++; if (rdy_seen !== 1'b0) begin errors++; $display("FAIL store_noc2_ready_during_tx got %0h exp 0", rdy_seen); end
    endtask

    task automatic test_drop();
        int d0 = drop_cnt;
        int l0 = lk_cnt;
        int n0 = n3_cnt;
        send_flit(mk_hdr(OWN_C, OWN_X ^ 8'h01, OWN_Y, 8'd4, 8'd16, 8'h07));
        for (int i = 0; i < 4; i++) send_flit(64'hDEAD_0000 + 64'(i));
        noc2_valid_in = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (drop_cnt - d0 != 1) begin errors++; $display("FAIL drop_pulses got %0d exp 1", drop_cnt - d0); end
        checks++; if (lk_cnt - l0 != 0) begin errors++; $display("FAIL drop_lookup got %0d exp 0", lk_cnt - l0); end
        checks++; if (n3_cnt - n0 != 0) begin errors++; $display("FAIL drop_noc3 got %0d exp 0", n3_cnt - n0); end
        checks++; if (noc2_ready_in !== 1'b1) begin errors++; $display("FAIL drop_idle_ready got %0h exp 1", noc2_ready_in); end
        send_flit(mk_hdr(OWN_C, OWN_X, OWN_Y, 8'd1, 8'h55, 8'h08));
        send_flit(64'h1);
        noc2_valid_in = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (drop_cnt - d0 != 2) begin errors++; $display("FAIL drop_len1_pulses got %0d exp 2", drop_cnt - d0); end
        checks++; if (noc2_ready_in !== 1'b1 || n3_cnt - n0 != 0) begin errors++; $display("FAIL drop_len1_idle got ready %0h noc3 %0d exp 1 0", noc2_ready_in, n3_cnt - n0); end
    endtask

    task automatic test_reset_mid();
        int n;
        int idx = 0;
        int t = 0;
        lookup_hit = 1'b1; lookup_dirty = 1'b1; lookup_data = {64'hD, 64'hC};
        send_msg(mk_hdr(OWN_C, OWN_X, OWN_Y, 8'd2, 8'd16, 8'h44), {24'h0, 40'h00_0000_1000}, mk_hdr(REQ_C, REQ_X, REQ_Y, 8'd0, 8'd0, 8'd0));
        while (t < 100) begin
            if (noc3_valid_out) begin
                if (idx == 2) break;
                idx++;
            end
            @(negedge clk); t++;
        end
        checks++; if (noc3_data_out !== 64'hC) begin errors++; $display("FAIL rstmid_d0 got %0h exp c", noc3_data_out); end
        rst_n = 1'b0;
        #1;
        checks++; if (noc3_valid_out !== 1'b0 || noc3_data_out !== 64'h0) begin errors++; $display("FAIL rstmid_noc3 got %0h %0h exp 0 0", noc3_valid_out, noc3_data_out); end
        checks++; if (noc2_ready_in !== 1'b1) begin errors++; $display("FAIL rstmid_noc2_ready got %0h exp 1", noc2_ready_in); end
        checks++; if (lookup_addr !== 40'h0 || lookup_valid !== 1'b0 || err_drop !== 1'b0) begin errors++; $display("FAIL rstmid_misc got %0h %0h %0h exp 0 0 0", lookup_addr, lookup_valid, err_drop); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_load(8'h45, 40'h00_0000_2000, {64'hF, 64'hE}, n);
        checks++; if (rx_n != 4 || rx[0] !== mk_hdr(REQ_C, REQ_X, REQ_Y, 8'd3, 8'd19, 8'h45)) begin errors++; $display("FAIL rstmid_after_hdr got %0h n %0d exp %0h n 4", rx[0], rx_n, mk_hdr(REQ_C, REQ_X, REQ_Y, 8'd3, 8'd19, 8'h45)); end
        checks++; if (rx[2] !== 64'hE || rx[3] !== 64'hF) begin errors++; $display("FAIL rstmid_after_data got %0h %0h exp e f", rx[2], rx[3]); end
    endtask

`ifdef L15_FWD_RESPONDER_STATS_EN
    task automatic test_stats();
        int n;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (cnt_fwd_rx !== 16'd0 || cnt_dirty_tx !== 16'd0 || cnt_drop !== 16'd0) begin errors++; $display("FAIL stats_reset got %0d %0d %0d exp 0 0 0", cnt_fwd_rx, cnt_dirty_tx, cnt_drop); end
        for (int i = 0; i < 3; i++) do_load(8'(i), 40'h100 + 40'(i), {64'h1, 64'h2}, n);
        send_msg(mk_hdr(OWN_C, OWN_X, OWN_Y, 8'd2, 8'h30, 8'h09), 64'h0, 64'h0);
        repeat (3) @(negedge clk);
        checks++; if (cnt_fwd_rx !== 16'd3) begin errors++; $display("FAIL stats_fwd_rx got %0d exp 3", cnt_fwd_rx); end
        checks++; if (cnt_dirty_tx !== 16'd3) begin errors++; $display("FAIL stats_dirty_tx got %0d exp 3", cnt_dirty_tx); end
        checks++; if (cnt_drop !== 16'd1) begin errors++; $display("FAIL stats_drop got %0d exp 1", cnt_drop); end
    endtask
`endif

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0;
        noc2_valid_in = 1'b0; noc2_data_in = '0; noc3_ready_out = 1'b1;
        lookup_hit = 1'b0; lookup_dirty = 1'b0; lookup_data = '0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_load_dirty();
        test_inv_miss();
        test_store_stall();
        test_drop();
        test_reset_mid();
`ifdef L15_FWD_RESPONDER_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
